// File: rtl/temp_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : temp_bcd_converter
// Purpose  : Sequential binary-to-BCD converter (double dabble, one input bit
//            per clock) producing hundreds/tens/ones digits for a temperature
//            display. Digits change only when a conversion completes.
// Ports    : clk             - system clock, rising edge
//            reset_n         - asynchronous active-low reset
//            start           - conversion request, honoured only in IDLE
//            bin_value       - unsigned binary temperature, INPUT_WIDTH bits
//            busy            - high while a conversion is in progress
//            done            - one-cycle pulse when new digits are valid
//            temp_value_100  - hundreds digit (registered)
//            temp_value_10   - tens digit (registered)
//            temp_value_1    - ones digit (registered)
// Params   : INPUT_WIDTH     - input width, 1..9
// Options  : TEMP_BCD_LEADING_BLANK_EN - when defined, leading zero digits are
//            replaced by 4'hF (blank) at result load; ones is never blanked.
// Revision : 1.0 - initial release
// ============================================================================
module temp_bcd_converter #(
  parameter int INPUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [INPUT_WIDTH-1:0] bin_value,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             temp_value_100,
  output logic [3:0]             temp_value_10,
  output logic [3:0]             temp_value_1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter value seen during the final SHIFT cycle.
  localparam logic [3:0] C_LAST_BIT = 4'(INPUT_WIDTH - 1);

  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] operand_q, operand_d;
  logic [11:0]            scratch_q, scratch_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [3:0]             hund_q, hund_d;
  logic [3:0]             tens_q, tens_d;
  logic [3:0]             ones_q, ones_d;

  logic [11:0]            scratch_adj;

  // Nibble correction so that the following left shift carries into the
  // next decimal digit instead of producing 10..15.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;

    scratch_adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d = bin_value;
          scratch_d = 12'd0;
          cnt_d     = 4'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Operand MSB falls into the ones nibble.
        {scratch_d, operand_d} = {scratch_adj, operand_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == C_LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef TEMP_BCD_LEADING_BLANK_EN
        hund_d = (scratch_q[11:8] == 4'd0) ? 4'hF : scratch_q[11:8];
        tens_d = ((scratch_q[11:8] == 4'd0) && (scratch_q[7:4] == 4'd0)) ? 4'hF : scratch_q[7:4];
        ones_d = scratch_q[3:0];
`else
        hund_d = scratch_q[11:8];
        tens_d = scratch_q[7:4];
        ones_d = scratch_q[3:0];
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      operand_q <= '0;
      scratch_q <= 12'd0;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  // Busy covers SHIFT and DONE; the done pulse appears once back in IDLE,
  // so the two never overlap.
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign temp_value_100 = hund_q;
  assign temp_value_10  = tens_q;
  assign temp_value_1   = ones_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_bcd_converter
// Purpose  : Self-checking bench for temp_bcd_converter. Expected digits come
//            from decimal arithmetic (/100, /10, %10) on the input value.
// Options  : TEMP_BCD_LEADING_BLANK_EN - enables blanked-digit expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_bcd_converter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] bin_value;
  logic         busy;
  logic         done;
  logic [3:0]   temp_value_100;
  logic [3:0]   temp_value_10;
  logic [3:0]   temp_value_1;

  int checks   = 0;
  int failures = 0;

  temp_bcd_converter #(.INPUT_WIDTH(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .bin_value      (bin_value),
    .busy           (busy),
    .done           (done),
    .temp_value_100 (temp_value_100),
    .temp_value_10  (temp_value_10),
    .temp_value_1   (temp_value_1)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mask(input int v);
    return v & ((1 << W) - 1);
  endfunction

  // Reference: decimal digits of the value, packed {hundreds, tens, ones}.
  function automatic int model(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
`ifdef TEMP_BCD_LEADING_BLANK_EN
    if (h == 0 && t == 0) t = 15;
    if (h == 0) h = 15;
`endif
    return (h << 8) | (t << 4) | o;
  endfunction

  function automatic int digits();
    return {20'd0, temp_value_100, temp_value_10, temp_value_1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one conversion starting from a posedge+1 point in IDLE. With junk=1
  // start/bin_value are toggled randomly while the block is busy.
  task automatic convert(input int v_in, input bit junk);
    int  v, exp_d, old_d;
    bit  seen;
    v     = mask(v_in);
    exp_d = model(v);
    old_d = digits();
    start     = 1'b1;
    bin_value = v[W-1:0];
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k <= W + 4; k++) begin
      check_value("busy_done_overlap", int'(busy & done), 0);
      if (done) begin
        check_value("latency", k, W + 1);
        check_value("digits", digits(), exp_d);
        check_value("busy_after_done", int'(busy), 0);
        start = 1'b0;
        seen  = 1'b1;
        break;
      end
      if (k <= W) check_value("busy_during", int'(busy), 1);
      check_value("digits_hold", digits(), old_d);
      if (junk) begin
        start     = 1'($urandom % 2);
        bin_value = W'($urandom);
      end
      tick();
    end
    if (!seen) check_value("done_timeout", 0, 1);
    tick();
    check_value("done_single_pulse", int'(done), 0);
    check_value("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int first_done, second_done, prev_d, v;
    bit idle_seen;

    reset_n   = 1'b0;
    start     = 1'b0;
    bin_value = '0;
    tick();
    tick();
    check_value("reset_digits", digits(), 0);
    check_value("reset_busy", int'(busy), 0);
    check_value("reset_done", int'(done), 0);
    reset_n = 1'b1;

    // Directed: maximum, zero, small, round value.
    convert((1 << W) - 1, 1'b0);
    convert(0, 1'b0);
    convert(7, 1'b0);
    convert(100, 1'b0);

    // Held start across back-to-back conversions.
    convert(42, 1'b0);
    prev_d      = model(mask(42));
    start       = 1'b1;
    bin_value   = W'(mask(99));
    first_done  = -1;
    second_done = -1;
    for (int c = 1; c <= 3 * W + 8; c++) begin
      tick();
      check_value("b2b_overlap", int'(busy & done), 0);
      if (done) begin
        if (first_done < 0) first_done = c;
        else begin
          second_done = c;
          break;
        end
      end else if (first_done < 0) begin
        check_value("b2b_hold", digits(), prev_d);
      end
    end
    check_value("b2b_first_done", first_done, W + 2);
    check_value("b2b_spacing", second_done - first_done, W + 2);
    check_value("b2b_digits", digits(), model(mask(99)));
    start     = 1'b0;
    idle_seen = 1'b0;
    for (int c = 0; c < 2 * W + 6; c++) begin
      tick();
      if (!busy && !done) begin
        idle_seen = 1'b1;
        break;
      end
    end
    check_value("b2b_idle", int'(idle_seen), 1);

    // Reset mid-SHIFT aborts with no done.
    start     = 1'b1;
    bin_value = W'(mask(200));
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check_value("abort_digits", digits(), 0);
    check_value("abort_busy", int'(busy), 0);
    check_value("abort_done", int'(done), 0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < W + 3; c++) begin
      tick();
      check_value("abort_no_done", int'(done), 0);
      check_value("abort_no_busy", int'(busy), 0);
    end
    convert(13, 1'b0);

    // Random conversions with random idle gaps and ignored start activity.
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      v = int'($urandom % (1 << W));
      convert(v, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
